// File: rtl/register_port_arbiter_pkg.sv
// rtl/register_port_arbiter_pkg.sv - shared encodings for the register port-A arbiter
package register_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WAIT    = 2'd1,
        ARB_CAPTURE = 2'd2,
        ARB_ACKED   = 2'd3
    } arb_state_t;

    localparam logic RF_DSEL_SEQ = 1'b0;
    localparam logic RF_DSEL_DBG = 1'b1;

    localparam logic [1:0] REG_BYTE_ENX_NONE = 2'b00;
    localparam logic [1:0] REG_BYTE_ENX_LOW  = 2'b01;
    localparam logic [1:0] REG_BYTE_ENX_HIGH = 2'b10;
    localparam logic [1:0] REG_BYTE_ENX_BOTH = 2'b11;

    typedef struct packed {
        logic       en;
        logic       wen;
        logic [1:0] byte_en;
        logic [3:0] addr;
    } port_req_t;

endpackage

// File: rtl/register_port_arbiter_port_mux.sv
// rtl/register_port_arbiter_port_mux.sv - combinational port-A select between sequencer and debug
module register_port_arbiter_port_mux
    import register_port_arbiter_pkg::*;
(
    input  logic      i_grant,
    input  port_req_t i_seq,
    input  port_req_t i_dbg,
    output port_req_t o_port,
    output logic      o_dsel
);

    assign o_port = i_grant ? i_dbg : i_seq;
    assign o_dsel = i_grant ? RF_DSEL_DBG : RF_DSEL_SEQ;

endmodule

// File: rtl/register_port_arbiter.sv
// rtl/register_port_arbiter.sv - slots debug register accesses into idle port-A cycles
module register_port_arbiter
    import register_port_arbiter_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetch,
    input  logic        i_decode,
    input  logic        i_execute,
    input  logic        i_commit,
    input  logic        i_halted,
    input  logic        i_seq_a_en,
    input  logic        i_seq_a_wen,
    input  logic [1:0]  i_seq_a_byte_en,
    input  logic [3:0]  i_seq_a_addr,
    input  logic        i_seq_b_en,
    input  logic        i_seq_b_wen,
    input  logic        i_dbg_req,
    input  logic        i_dbg_wen,
    input  logic [1:0]  i_dbg_byte_en,
    input  logic [3:0]  i_dbg_addr,
    input  logic [15:0] i_rf_a_dout,
    output logic        o_rf_a_en,
    output logic        o_rf_a_wen,
    output logic [1:0]  o_rf_a_byte_en,
    output logic [3:0]  o_rf_a_addr,
    output logic        o_rf_a_dsel,
    output logic        o_rf_b_en,
    output logic        o_rf_b_wen,
    output logic        o_dbg_ack,
    output logic [15:0] o_dbg_dout,
    output logic        o_collision
);

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic        r_armed;
    logic        r_wen;
    logic [1:0]  r_byte_en;
    logic [3:0]  r_addr;
    logic [15:0] r_dbg_dout;
    logic        r_collision;

    logic        w_open;
    logic        w_seq_busy;
    logic        w_grant;
    port_req_t   w_seq_req;
    port_req_t   w_dbg_req;
    port_req_t   w_port;
    logic        w_unused_phases;

    // The other phases only matter through the sequencer enables they produce.
    assign w_unused_phases = i_decode ^ i_execute ^ i_commit;

    assign w_open     = i_fetch | i_halted;
    assign w_seq_busy = i_seq_a_en | i_seq_a_wen | i_seq_b_en | i_seq_b_wen;
    // A colliding cycle is left to the sequencer; the debug access waits for a clean slot.
    assign w_grant    = (r_state == ARB_WAIT) & i_dbg_req & w_open & ~w_seq_busy;

    assign w_seq_req = '{en: i_seq_a_en, wen: i_seq_a_wen,
                         byte_en: i_seq_a_byte_en, addr: i_seq_a_addr};
    assign w_dbg_req = '{en: 1'b1, wen: r_wen,
                         byte_en: r_wen ? r_byte_en : REG_BYTE_ENX_BOTH, addr: r_addr};

    register_port_arbiter_port_mux u_port_mux (
        .i_grant (w_grant),
        .i_seq   (w_seq_req),
        .i_dbg   (w_dbg_req),
        .o_port  (w_port),
        .o_dsel  (o_rf_a_dsel)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE:    if (i_dbg_req && r_armed) w_next_state = ARB_WAIT;
            ARB_WAIT: begin
                if (w_grant)         w_next_state = r_wen ? ARB_ACKED : ARB_CAPTURE;
                else if (!i_dbg_req) w_next_state = ARB_IDLE;
            end
            ARB_CAPTURE: w_next_state = ARB_ACKED;
            ARB_ACKED:   w_next_state = ARB_IDLE;
            default:     w_next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ARB_IDLE;
            r_armed     <= 1'b1;
            r_wen       <= 1'b0;
            r_byte_en   <= REG_BYTE_ENX_NONE;
            r_addr      <= 4'h0;
            r_dbg_dout  <= 16'h0000;
            r_collision <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ARB_IDLE && i_dbg_req && r_armed) begin
                r_wen     <= i_dbg_wen;
                r_byte_en <= i_dbg_byte_en;
                r_addr    <= i_dbg_addr;
            end
            // Re-arm only once the requester has dropped its level after the ACK.
            if (r_state == ARB_ACKED)
                r_armed <= 1'b0;
            else if (!i_dbg_req)
                r_armed <= 1'b1;
            if (r_state == ARB_CAPTURE)
                r_dbg_dout <= i_rf_a_dout;
            if (w_open && w_seq_busy)
                r_collision <= 1'b1;
        end
    end

    assign o_rf_a_en      = w_port.en;
    assign o_rf_a_wen     = w_port.wen;
    assign o_rf_a_byte_en = w_port.byte_en;
    assign o_rf_a_addr    = w_port.addr;
    assign o_rf_b_en      = i_seq_b_en;
    assign o_rf_b_wen     = i_seq_b_wen;
    assign o_dbg_ack      = (r_state == ARB_ACKED);
    assign o_dbg_dout     = r_dbg_dout;
    assign o_collision    = r_collision;

endmodule

// File: tb/tb_register_port_arbiter.sv
// tb/tb_register_port_arbiter.sv - directed checks of the register port-A arbiter
module tb_register_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch, decode, execute, commit, halted;
    logic        seq_a_en, seq_a_wen, seq_b_en, seq_b_wen;
    logic [1:0]  seq_a_be;
    logic [3:0]  seq_a_addr;
    logic        dbg_req, dbg_wen;
    logic [1:0]  dbg_be;
    logic [3:0]  dbg_addr;
    logic [15:0] rf_dout = 16'h0000;
    logic        rf_a_en, rf_a_wen, rf_a_dsel, rf_b_en, rf_b_wen;
    logic [1:0]  rf_a_be;
    logic [3:0]  rf_a_addr;
    logic        dbg_ack, collision;
    logic [15:0] dbg_dout;

    logic [15:0] mem [16];
    logic        n_req, n_wen;
    logic [1:0]  n_be;
    logic [3:0]  n_addr;
    int          passed = 0;
    int          total  = 0;

    typedef struct {
        int         ph;
        logic       a_en;
        logic       a_wen;
        logic [1:0] a_be;
        logic [3:0] a_addr;
        logic       b_en;
        logic       b_wen;
        logic [8:0] exp_a;
        logic [1:0] exp_b;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    register_port_arbiter dut (
        .i_clk(clk), .i_rst(rst),
        .i_fetch(fetch), .i_decode(decode), .i_execute(execute), .i_commit(commit),
        .i_halted(halted),
        .i_seq_a_en(seq_a_en), .i_seq_a_wen(seq_a_wen), .i_seq_a_byte_en(seq_a_be),
        .i_seq_a_addr(seq_a_addr), .i_seq_b_en(seq_b_en), .i_seq_b_wen(seq_b_wen),
        .i_dbg_req(dbg_req), .i_dbg_wen(dbg_wen), .i_dbg_byte_en(dbg_be), .i_dbg_addr(dbg_addr),
        .i_rf_a_dout(rf_dout),
        .o_rf_a_en(rf_a_en), .o_rf_a_wen(rf_a_wen), .o_rf_a_byte_en(rf_a_be),
        .o_rf_a_addr(rf_a_addr), .o_rf_a_dsel(rf_a_dsel),
        .o_rf_b_en(rf_b_en), .o_rf_b_wen(rf_b_wen),
        .o_dbg_ack(dbg_ack), .o_dbg_dout(dbg_dout), .o_collision(collision)
    );

    // Register file read port: one-cycle registered read.
    always @(posedge clk)
        if (rf_a_en && !rf_a_wen) rf_dout <= mem[rf_a_addr];

    function automatic logic [8:0] porta();
        return {rf_a_en, rf_a_wen, rf_a_be, rf_a_addr, rf_a_dsel};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_phase(input int ph);
        fetch   = (ph == 0);
        decode  = (ph == 1);
        execute = (ph == 2);
        commit  = (ph == 3);
        halted  = (ph == 4);
    endtask

    // Advance one cycle: sequencer runs RDA_RDB (DECODE reads r1 on A and B, COMMIT writes B).
    task automatic tick(input int ph, input logic force_a);
        @(negedge clk);
        set_phase(ph);
        seq_a_en = 1'b0; seq_a_wen = 1'b0; seq_a_be = 2'b00; seq_a_addr = 4'h0;
        seq_b_en = 1'b0; seq_b_wen = 1'b0;
        if (ph == 1) begin
            seq_a_en = 1'b1; seq_a_be = 2'b11; seq_a_addr = 4'h1; seq_b_en = 1'b1;
        end
        if (ph == 3) begin
            seq_b_en = 1'b1; seq_b_wen = 1'b1;
        end
        if (force_a) begin
            seq_a_en = 1'b1; seq_a_be = 2'b11; seq_a_addr = 4'h1;
        end
        dbg_req = n_req; dbg_wen = n_wen; dbg_be = n_be; dbg_addr = n_addr;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        mem[1] = 16'h1111; mem[2] = 16'h1234; mem[5] = 16'hBEEF;
        rst = 1'b1;
        set_phase(5);
        seq_a_en = 0; seq_a_wen = 0; seq_a_be = 0; seq_a_addr = 0; seq_b_en = 0; seq_b_wen = 0;
        dbg_req = 0; dbg_wen = 0; dbg_be = 0; dbg_addr = 0;
        n_req = 0; n_wen = 0; n_be = 0; n_addr = 0;

        vecs[0] = '{1, 1'b1, 1'b0, 2'b11, 4'h4, 1'b1, 1'b0, 9'b1_0_11_0100_0, 2'b10};
        vecs[1] = '{2, 1'b1, 1'b1, 2'b01, 4'hA, 1'b1, 1'b1, 9'b1_1_01_1010_0, 2'b11};
        vecs[2] = '{3, 1'b0, 1'b0, 2'b10, 4'hF, 1'b0, 1'b0, 9'b0_0_10_1111_0, 2'b00};
        vecs[3] = '{0, 1'b0, 1'b0, 2'b10, 4'h6, 1'b0, 1'b0, 9'b0_0_10_0110_0, 2'b00};
        vecs[4] = '{4, 1'b0, 1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 9'b0_0_00_0000_0, 2'b00};
        vecs[5] = '{1, 1'b1, 1'b0, 2'b10, 4'h2, 1'b0, 1'b1, 9'b1_0_10_0010_0, 2'b01};

        repeat (2) @(negedge clk);
        #1;
        check("reset_ack", dbg_ack, 0);
        check("reset_dout", dbg_dout, 16'h0000);
        check("reset_collision", collision, 0);
        check("reset_dsel", rf_a_dsel, 0);
        check("reset_porta_zero", porta(), 9'h000);
        rst = 1'b0;

        // Idle pass-through vectors.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_phase(vecs[i].ph);
            seq_a_en = vecs[i].a_en; seq_a_wen = vecs[i].a_wen; seq_a_be = vecs[i].a_be;
            seq_a_addr = vecs[i].a_addr; seq_b_en = vecs[i].b_en; seq_b_wen = vecs[i].b_wen;
            #1;
            check($sformatf("pass_a_%0d", i), porta(), vecs[i].exp_a);
            check($sformatf("pass_b_%0d", i), {rf_b_en, rf_b_wen}, vecs[i].exp_b);
            check($sformatf("pass_ack_%0d", i), dbg_ack, 0);
        end
        check("pass_collision", collision, 0);

        // Debug write raised in EXECUTE, slotted into FETCH, ACK in DECODE.
        n_req = 1; n_wen = 1; n_be = 2'b01; n_addr = 4'h3;
        tick(2, 0); check("wr_latch_ack", dbg_ack, 0);
        tick(3, 0); check("wr_wait_dsel", rf_a_dsel, 0);
        tick(0, 0); check("wr_slot_porta", porta(), {1'b1, 1'b1, 2'b01, 4'h3, 1'b1});
        tick(1, 0); check("wr_ack", dbg_ack, 1);
        check("wr_ack_porta_seq", porta(), {1'b1, 1'b0, 2'b11, 4'h1, 1'b0});
        n_req = 0;
        tick(2, 0); check("wr_ack_pulse", dbg_ack, 0);
        tick(3, 0);

        // Debug read of r5 in FETCH, ACK in EXECUTE with data; sequencer DECODE read intact.
        n_req = 1; n_wen = 0; n_be = 2'b00; n_addr = 4'h5;
        tick(2, 0); tick(3, 0);
        tick(0, 0); check("rd_slot_porta", porta(), {1'b1, 1'b0, 2'b11, 4'h5, 1'b1});
        tick(1, 0); check("rd_capture_porta", porta(), {1'b1, 1'b0, 2'b11, 4'h1, 1'b0});
        check("rd_capture_ack", dbg_ack, 0);
        tick(2, 0); check("rd_ack", dbg_ack, 1);
        check("rd_dout", dbg_dout, 16'hBEEF);
        check("rd_seq_decode_data", rf_dout, 16'h1111);
        n_req = 0;
        tick(3, 0);

        // Halted read of r2: slot the cycle after latching, ACK three cycles after request.
        n_req = 1; n_wen = 0; n_addr = 4'h2;
        tick(4, 0); check("halt_latch_dsel", rf_a_dsel, 0);
        tick(4, 0); check("halt_slot_porta", porta(), {1'b1, 1'b0, 2'b11, 4'h2, 1'b1});
        tick(4, 0); check("halt_capture_ack", dbg_ack, 0);
        tick(4, 0); check("halt_ack", dbg_ack, 1);
        check("halt_dout", dbg_dout, 16'h1234);
        n_req = 0;
        tick(4, 0); tick(3, 0);

        // Collision: sequencer forces port A in FETCH; debug read slips a full rotation.
        check("coll_before", collision, 0);
        n_req = 1; n_wen = 0; n_addr = 4'h5;
        tick(2, 0); tick(3, 0);
        tick(0, 1); check("coll_seq_owns", porta(), {1'b1, 1'b0, 2'b11, 4'h1, 1'b0});
        tick(1, 0); check("coll_set", collision, 1);
        check("coll_no_ack", dbg_ack, 0);
        tick(2, 0); tick(3, 0);
        tick(0, 0); check("coll_slot_porta", porta(), {1'b1, 1'b0, 2'b11, 4'h5, 1'b1});
        tick(1, 0);
        tick(2, 0); check("coll_ack", dbg_ack, 1);
        check("coll_dout", dbg_dout, 16'hBEEF);
        check("coll_sticky", collision, 1);
        n_req = 0;
        tick(3, 0);

        // Reset while in CAPTURE discards the read.
        n_req = 1; n_wen = 0; n_addr = 4'h2;
        tick(2, 0); tick(3, 0); tick(0, 0);
        tick(1, 0);
        rst = 1'b1;
        #1;
        check("rst_cap_ack", dbg_ack, 0);
        check("rst_cap_dout", dbg_dout, 16'h0000);
        check("rst_cap_collision", collision, 0);
        n_req = 0;
        tick(2, 0); check("rst_hold_ack", dbg_ack, 0);
        rst = 1'b0;
        tick(3, 0); check("rst_after_ack", dbg_ack, 0);
        n_req = 1;
        tick(2, 0); tick(3, 0);
        tick(0, 0); check("post_rst_slot", porta(), {1'b1, 1'b0, 2'b11, 4'h2, 1'b1});
        tick(1, 0);
        tick(2, 0); check("post_rst_ack", dbg_ack, 1);
        check("post_rst_dout", dbg_dout, 16'h1234);
        n_req = 0;
        tick(3, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
